// File: rtl/ervp_tick_watchdog.sv
// ervp_tick_watchdog
// Tick-driven watchdog. It counts down a programmable timeout using either the
// 1 us or the 62.5 ms tick, raises a sticky warning interrupt at a chosen
// remaining count, and emits a fixed-length bark pulse when the count runs
// out. Every output is driven straight from a flop.

module ervp_tick_watchdog #(
    parameter int BW_TIMEOUT      = 16,
    parameter int BW_EXPIRE_COUNT = 8,
    parameter int BARK_CYCLES     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_1us,
    input  logic                       tick_62d5ms,
    input  logic                       tick_sel,
    input  logic                       enable,
    input  logic                       lock_set,
    input  logic [BW_TIMEOUT-1:0]      timeout_value,
    input  logic [BW_TIMEOUT-1:0]      warn_value,
    input  logic                       kick,
    input  logic                       warn_clear,
    output logic [BW_TIMEOUT-1:0]      remaining,
    output logic [1:0]                 state,
    output logic                       warn_irq,
    output logic                       bark,
    output logic                       expired,
    output logic [BW_EXPIRE_COUNT-1:0] expire_count,
    output logic                       locked,
    output logic                       config_error
);

    localparam int BW_BARK_CNT = $clog2(BARK_CYCLES + 1);
    localparam logic [BW_BARK_CNT-1:0] BARK_LAST = BW_BARK_CNT'(BARK_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_WARN    = 3'd2,
        ST_BARK    = 3'd3,
        ST_EXPIRED = 3'd4
    } wd_state_e;

    // BARK and EXPIRED share one external code; the expired flag tells them apart.
    function automatic logic [1:0] encode_state(input wd_state_e s);
        logic [1:0] code;
        case (s)
            ST_IDLE:             code = 2'd0;
            ST_RUN:              code = 2'd1;
            ST_WARN:             code = 2'd2;
            ST_BARK, ST_EXPIRED: code = 2'd3;
            default:             code = 2'd0;
        endcase
        return code;
    endfunction

    // The expiry counter sticks at all-ones instead of wrapping.
    function automatic logic [BW_EXPIRE_COUNT-1:0] sat_inc(input logic [BW_EXPIRE_COUNT-1:0] v);
        logic [BW_EXPIRE_COUNT-1:0] r;
        if (v == {BW_EXPIRE_COUNT{1'b1}}) begin
            r = v;
        end else begin
            r = v + BW_EXPIRE_COUNT'(1);
        end
        return r;
    endfunction

    wd_state_e                  state_r, state_s;
    logic [BW_TIMEOUT-1:0]      remaining_r, remaining_s;
    logic [BW_TIMEOUT-1:0]      dec_s;
    logic [1:0]                 state_code_r, state_code_s;
    logic                       warn_irq_r, warn_irq_s;
    logic                       warn_set_s;
    logic                       bark_r, bark_s;
    logic                       expired_r, expired_s;
    logic [BW_EXPIRE_COUNT-1:0] expire_count_r, expire_count_s;
    logic                       locked_r, locked_s;
    logic                       config_error_r, config_error_s;
    logic [BW_BARK_CNT-1:0]     bark_cnt_r, bark_cnt_s;
    logic                       tk_s;

    // Next-state, next-count and next-output logic for the watchdog FSM.
    always_comb begin
        tk_s           = tick_sel ? tick_1us : tick_62d5ms;
        dec_s          = remaining_r - BW_TIMEOUT'(1);
        state_s        = state_r;
        remaining_s    = remaining_r;
        warn_set_s     = 1'b0;
        bark_s         = 1'b0;
        expired_s      = 1'b0;
        expire_count_s = expire_count_r;
        config_error_s = config_error_r;
        bark_cnt_s     = bark_cnt_r;

        case (state_r)
            ST_IDLE: begin
                remaining_s = '0;
                if (enable) begin
                    if (timeout_value != '0) begin
                        remaining_s    = timeout_value;
                        state_s        = ST_RUN;
                        config_error_s = 1'b0;
                    end else begin
                        config_error_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN, ST_WARN: begin
                if (!enable && !locked_r) begin
                    state_s     = ST_IDLE;
                    remaining_s = '0;
                end else if (kick) begin
                    // A kick outranks a coincident tick: reload, no decrement.
                    remaining_s = timeout_value;
                    state_s     = ST_RUN;
                end else if (tk_s) begin
                    remaining_s = dec_s;
                    if (dec_s == '0) begin
                        state_s        = ST_BARK;
                        bark_s         = 1'b1;
                        bark_cnt_s     = BW_BARK_CNT'(1);
                        expire_count_s = sat_inc(expire_count_r);
                    end else if ((warn_value != '0) && (dec_s == warn_value) &&
                                 (state_r == ST_RUN)) begin
                        state_s    = ST_WARN;
                        warn_set_s = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_BARK: begin
                // bark_cnt_r holds how many bark cycles have already been shown.
                remaining_s = '0;
                if (bark_cnt_r == BARK_LAST) begin
                    bark_cnt_s = '0;
                    state_s    = ST_EXPIRED;
                    expired_s  = 1'b1;
                end else begin
                    bark_cnt_s = bark_cnt_r + BW_BARK_CNT'(1);
                    bark_s     = 1'b1;
                end
            end

            ST_EXPIRED: begin
                remaining_s = '0;
                if (!enable) begin
                    state_s = ST_IDLE;
                end else begin
                    expired_s = 1'b1;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                remaining_s = '0;
                bark_cnt_s  = '0;
            end
        endcase

        if (warn_set_s) begin
            warn_irq_s = 1'b1;
        end else if (warn_clear) begin
            warn_irq_s = 1'b0;
        end else begin
            warn_irq_s = warn_irq_r;
        end

        locked_s     = locked_r | lock_set;
        state_code_s = encode_state(state_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            remaining_r    <= '0;
            state_code_r   <= 2'd0;
            warn_irq_r     <= 1'b0;
            bark_r         <= 1'b0;
            expired_r      <= 1'b0;
            expire_count_r <= '0;
            locked_r       <= 1'b0;
            config_error_r <= 1'b0;
            bark_cnt_r     <= '0;
        end else begin
            state_r        <= state_s;
            remaining_r    <= remaining_s;
            state_code_r   <= state_code_s;
            warn_irq_r     <= warn_irq_s;
            bark_r         <= bark_s;
            expired_r      <= expired_s;
            expire_count_r <= expire_count_s;
            locked_r       <= locked_s;
            config_error_r <= config_error_s;
            bark_cnt_r     <= bark_cnt_s;
        end
    end

    assign remaining    = remaining_r;
    assign state        = state_code_r;
    assign warn_irq     = warn_irq_r;
    assign bark         = bark_r;
    assign expired      = expired_r;
    assign expire_count = expire_count_r;
    assign locked       = locked_r;
    assign config_error = config_error_r;

endmodule

// File: tb/tb_ervp_tick_watchdog.sv
// Bench for ervp_tick_watchdog: a vector table for the warning-then-bark
// scenario, hand-written multi-cycle sequences, and randomized traffic, all
// checked against a behavioural model of the watchdog.

module tb_ervp_tick_watchdog;

    localparam int BWT    = 16;
    localparam int BWE    = 2;
    localparam int BC     = 8;
    localparam int EC_MAX = (1 << BWE) - 1;

    logic clk = 1'b0;
    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    logic           rst, tick_1us, tick_62d5ms, tick_sel, enable, lock_set, kick, warn_clear;
    logic [BWT-1:0] timeout_value, warn_value, remaining;
    logic [1:0]     state;
    logic           warn_irq, bark, expired, locked, config_error;
    logic [BWE-1:0] expire_count;

    ervp_tick_watchdog #(
        .BW_TIMEOUT(BWT),
        .BW_EXPIRE_COUNT(BWE),
        .BARK_CYCLES(BC)
    ) dut (
        .clk(clk), .rst(rst), .tick_1us(tick_1us), .tick_62d5ms(tick_62d5ms),
        .tick_sel(tick_sel), .enable(enable), .lock_set(lock_set),
        .timeout_value(timeout_value), .warn_value(warn_value), .kick(kick),
        .warn_clear(warn_clear), .remaining(remaining), .state(state),
        .warn_irq(warn_irq), .bark(bark), .expired(expired),
        .expire_count(expire_count), .locked(locked), .config_error(config_error)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phases as flags, bark as a cycles-left countdown.
    logic [BWT-1:0] m_rem;
    bit  m_run, m_warned, m_exp, m_wi, m_lock, m_cfg;
    int  m_bark_left, m_ec;

    function automatic int m_state();
        if (m_bark_left > 0 || m_exp) return 3;
        else if (m_run) return m_warned ? 2 : 1;
        else return 0;
    endfunction

    task automatic model_edge();
        bit tk, set_w, old_lock;
        if (rst) begin
            m_rem = '0; m_run = 0; m_warned = 0; m_exp = 0; m_wi = 0;
            m_lock = 0; m_cfg = 0; m_bark_left = 0; m_ec = 0;
        end else begin
            tk = tick_sel ? tick_1us : tick_62d5ms;
            set_w = 0;
            old_lock = m_lock;
            if (m_bark_left > 0) begin
                m_bark_left--;
                if (m_bark_left == 0) m_exp = 1;
            end else if (m_exp) begin
                if (!enable) m_exp = 0;
            end else if (m_run) begin
                if (!enable && !old_lock) begin
                    m_run = 0; m_warned = 0; m_rem = '0;
                end else if (kick) begin
                    m_rem = timeout_value; m_warned = 0;
                end else if (tk) begin
                    m_rem = m_rem - 16'd1;
                    if (m_rem == 0) begin
                        m_run = 0; m_warned = 0; m_bark_left = BC;
                        if (m_ec < EC_MAX) m_ec++;
                    end else if (warn_value != 0 && m_rem == warn_value && !m_warned) begin
                        m_warned = 1; set_w = 1;
                    end
                end
            end else if (enable) begin
                if (timeout_value != 0) begin
                    m_rem = timeout_value; m_run = 1; m_warned = 0; m_cfg = 0;
                end else begin
                    m_cfg = 1;
                end
            end
            m_lock = m_lock | lock_set;
            if (set_w) m_wi = 1;
            else if (warn_clear) m_wi = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("remaining",    int'(remaining),    int'(m_rem));
        chk("state",        int'(state),        m_state());
        chk("warn_irq",     int'(warn_irq),     int'(m_wi));
        chk("bark",         int'(bark),         (m_bark_left > 0) ? 1 : 0);
        chk("expired",      int'(expired),      int'(m_exp));
        chk("expire_count", int'(expire_count), m_ec);
        chk("locked",       int'(locked),       int'(m_lock));
        chk("config_error", int'(config_error), int'(m_cfg));
    endtask

    // One clock: model advances on the edge, outputs sampled 1 ns later, pulses dropped.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
        rst = 1'b0; tick_1us = 1'b0; tick_62d5ms = 1'b0;
        kick = 1'b0; warn_clear = 1'b0; lock_set = 1'b0;
    endtask

    typedef struct {
        logic       rst, en, sel, t1, t62, kick, wclr;
        logic [15:0] tmo, wrn, e_rem;
        logic [1:0]  e_st;
        logic        e_wi, e_bark, e_exp;
    } vec_t;

    vec_t tbl [8];
    int   min_rem;

    initial begin
        rst = 1'b0; tick_1us = 1'b0; tick_62d5ms = 1'b0; tick_sel = 1'b1; enable = 1'b0;
        lock_set = 1'b0; kick = 1'b0; warn_clear = 1'b0;
        timeout_value = 16'd4; warn_value = 16'd1;
        m_rem = '0; m_run = 0; m_warned = 0; m_exp = 0; m_wi = 0;
        m_lock = 0; m_cfg = 0; m_bark_left = 0; m_ec = 0;

        //          rst  en   sel  t1   t62  kick wclr tmo    wrn    rem    st    wi   bark exp
        tbl[0] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'd4,16'd1,16'd0,2'd0,1'b0,1'b0,1'b0};
        tbl[1] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'd4,16'd1,16'd4,2'd1,1'b0,1'b0,1'b0};
        tbl[2] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'd4,16'd1,16'd3,2'd1,1'b0,1'b0,1'b0};
        tbl[3] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,16'd4,16'd1,16'd3,2'd1,1'b0,1'b0,1'b0};
        tbl[4] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'd4,16'd1,16'd2,2'd1,1'b0,1'b0,1'b0};
        tbl[5] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'd4,16'd1,16'd1,2'd2,1'b1,1'b0,1'b0};
        tbl[6] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'd4,16'd1,16'd0,2'd3,1'b1,1'b1,1'b0};
        tbl[7] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,16'd4,16'd1,16'd0,2'd3,1'b1,1'b1,1'b0};

        // Warning then bark, from the table.
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en; tick_sel = tbl[i].sel;
            tick_1us = tbl[i].t1; tick_62d5ms = tbl[i].t62; kick = tbl[i].kick;
            warn_clear = tbl[i].wclr; timeout_value = tbl[i].tmo; warn_value = tbl[i].wrn;
            step();
            chk($sformatf("tbl%0d_rem", i),  int'(remaining), int'(tbl[i].e_rem));
            chk($sformatf("tbl%0d_st", i),   int'(state),     int'(tbl[i].e_st));
            chk($sformatf("tbl%0d_wi", i),   int'(warn_irq),  int'(tbl[i].e_wi));
            chk($sformatf("tbl%0d_bark", i), int'(bark),      int'(tbl[i].e_bark));
            chk($sformatf("tbl%0d_exp", i),  int'(expired),   int'(tbl[i].e_exp));
        end
        // Remaining bark cycles 3..8, then EXPIRED.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bark_held", int'(bark), 1);
        end
        step();
        chk("bark_end", int'(bark), 0);
        chk("expired_set", int'(expired), 1);
        chk("expired_state", int'(state), 3);
        chk("expire_count1", int'(expire_count), 1);
        step();
        chk("expired_needs_enable_low", int'(expired), 1);

        // Regular kicks keep the count well away from the warning point.
        enable = 1'b0; step();
        chk("idle_after_expired", int'(state), 0);
        chk("warn_sticky_idle", int'(warn_irq), 1);
        warn_clear = 1'b1; step();
        chk("warn_cleared_idle", int'(warn_irq), 0);
        enable = 1'b1; step();
        chk("restart_rem", int'(remaining), 4);
        min_rem = 4;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 2) kick = 1'b1; else tick_1us = 1'b1;
            step();
            if (int'(remaining) < min_rem) min_rem = int'(remaining);
            if (bark || warn_irq) chk("kick_no_bark_warn", int'({bark, warn_irq}), 0);
        end
        chk("kick_min_rem", min_rem, 2);
        chk("kick_warn_irq", int'(warn_irq), 0);

        // Kick with a coincident tick, then warn_clear against a warning tick.
        tick_1us = 1'b1; step();
        tick_1us = 1'b1; step();
        chk("pre_kick_rem", int'(remaining), 2);
        kick = 1'b1; tick_1us = 1'b1; step();
        chk("kick_tk_rem", int'(remaining), 4);
        chk("kick_tk_state", int'(state), 1);
        tick_1us = 1'b1; step();
        tick_1us = 1'b1; step();
        tick_1us = 1'b1; warn_clear = 1'b1; step();
        chk("set_beats_clear", int'(warn_irq), 1);
        chk("warn_state", int'(state), 2);
        kick = 1'b1; step();
        chk("kick_from_warn_state", int'(state), 1);
        chk("kick_from_warn_rem", int'(remaining), 4);
        warn_clear = 1'b1; step();
        chk("warn_clear", int'(warn_irq), 0);

        // Lock makes enable-deassert ineffective until reset.
        lock_set = 1'b1; step();
        chk("locked_set", int'(locked), 1);
        enable = 1'b0; step();
        chk("locked_run", int'(state), 1);
        tick_1us = 1'b1; step();
        chk("locked_counting", int'(remaining), 3);
        rst = 1'b1; step();
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_rem", int'(remaining), 0);
        chk("rst_ecount", int'(expire_count), 0);

        // Config error on a zero timeout, cleared by a good start.
        timeout_value = 16'd0; enable = 1'b1; step();
        chk("cfg_err_set", int'(config_error), 1);
        chk("cfg_err_idle", int'(state), 0);
        enable = 1'b0; timeout_value = 16'd3; step();
        enable = 1'b1; step();
        chk("cfg_restart_state", int'(state), 1);
        chk("cfg_restart_rem", int'(remaining), 3);
        chk("cfg_err_clear", int'(config_error), 0);

        // Four expiries into a 2-bit counter; 62.5 ms tick path.
        warn_value = 16'd0; tick_sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enable = 1'b0; step();
            enable = 1'b1; timeout_value = 16'd1; step();
            tick_62d5ms = 1'b1; step();
            chk("sat_bark_entry", int'(bark), 1);
            chk("sat_count", int'(expire_count), (k + 1 > 3) ? 3 : k + 1);
            for (int j = 0; j < BC; j++) step();
            chk("sat_expired", int'(expired), 1);
        end
        // Reset in the middle of a bark.
        enable = 1'b0; step();
        enable = 1'b1; step();
        tick_62d5ms = 1'b1; step();
        step(); step(); step();
        chk("mid_bark_high", int'(bark), 1);
        rst = 1'b1; step();
        chk("rst_mid_bark", int'(bark), 0);
        chk("rst_mid_bark_state", int'(state), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(299) == 0);
            if ($urandom_range(24) == 0) enable = ~enable;
            if ($urandom_range(49) == 0) tick_sel = ~tick_sel;
            tick_1us    = ($urandom_range(2) == 0);
            tick_62d5ms = ($urandom_range(3) == 0);
            kick        = ($urandom_range(11) == 0);
            warn_clear  = ($urandom_range(9) == 0);
            lock_set    = ($urandom_range(399) == 0);
            if ($urandom_range(59) == 0) timeout_value = 16'($urandom_range(10, 1));
            if ($urandom_range(59) == 0) warn_value = 16'($urandom_range(10));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
